servive_rst_seq: RTL and testbench

Parametrised reset sequencer for multi-core servive platforms, replacing the single-core fixed reset path between the clock generator and the SoC. It holds the Wishbone bus and every core in reset until the clock source reports lock and a stretch interval has elapsed. It then releases the bus and staggers per-core reset release, and supports per-core software reset pulses at run time.

---
 rtl/servive_rst_seq_pkg.sv | 17 +
 rtl/servive_sync.sv | 23 ++
 rtl/servive_rst_seq.sv | 158 +++++++++++++++
 tb/tb_servive_rst_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/servive_rst_seq_pkg.sv
// Shared types and helpers for the servive reset sequencer.
// Holds the FSM state encoding used by the RTL and by state checks in the bench.
package servive_rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_LOCK    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_STAGGER = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/servive_sync.sv
// N-stage asynchronous-reset synchroniser, width 1, clears to 0.
module servive_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/servive_rst_seq.sv
// Reset sequencer: holds bus and cores in reset until lock plus stretch,
// then releases the bus, staggers core releases and serves soft core resets.
module servive_rst_seq
  import servive_rst_seq_pkg::*;
#(
  parameter int unsigned CORE_COUNT     = 1,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned SOFT_CYCLES    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pll_locked,
  input  logic [CORE_COUNT-1:0] i_core_rst_req,
  output logic                  o_wb_rst,
  output logic [CORE_COUNT-1:0] o_core_rst,
  output logic                  o_ready
);

  localparam int unsigned STR_W   = cnt_w(STRETCH_CYCLES - 1);
  localparam int unsigned STG_MAX = CORE_COUNT * STAGGER_CYCLES;
  localparam int unsigned STG_W   = cnt_w(STG_MAX);
  localparam int unsigned SOFT_W  = cnt_w(SOFT_CYCLES);

  logic                  w_lock;
  state_e                r_state;
  state_e                w_state_nxt;
  logic [STR_W-1:0]      r_str_cnt;
  logic [STR_W-1:0]      w_str_cnt_nxt;
  logic [STG_W-1:0]      r_stg_cnt;
  logic [STG_W-1:0]      w_stg_cnt_nxt;
  logic [STG_W-1:0]      w_stg_inc;
  logic                  r_lock_lost;
  logic                  r_wb_rst;
  logic                  w_wb_rst_nxt;
  logic                  r_ready;
  logic                  w_ready_nxt;
  logic [CORE_COUNT-1:0] w_release;

  servive_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_pll_locked),
    .o_q   (w_lock)
  );

  // State register; a lock drop outside LOCK is flagged first, then aborts on the next edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_LOCK;
      r_str_cnt   <= '0;
      r_stg_cnt   <= '0;
      r_lock_lost <= 1'b0;
      r_wb_rst    <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_str_cnt   <= w_str_cnt_nxt;
      r_stg_cnt   <= w_stg_cnt_nxt;
      r_lock_lost <= !w_lock && (r_state != ST_LOCK) && !r_lock_lost;
      r_wb_rst    <= w_wb_rst_nxt;
      r_ready     <= w_ready_nxt;
    end
  end

  assign w_stg_inc = r_stg_cnt + STG_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_str_cnt_nxt = r_str_cnt;
    w_stg_cnt_nxt = r_stg_cnt;
    w_wb_rst_nxt  = r_wb_rst;
    w_ready_nxt   = r_ready;
    w_release     = '0;
    if (r_lock_lost) begin
      w_state_nxt   = ST_LOCK;
      w_str_cnt_nxt = '0;
      w_stg_cnt_nxt = '0;
      w_wb_rst_nxt  = 1'b1;
      w_ready_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_LOCK: begin
          if (w_lock) begin
            w_state_nxt   = ST_STRETCH;
            w_str_cnt_nxt = '0;
          end
        end
        ST_STRETCH: begin
          if (r_str_cnt == STR_W'(STRETCH_CYCLES - 1)) begin
            w_state_nxt   = ST_STAGGER;
            w_str_cnt_nxt = '0;
            w_stg_cnt_nxt = '0;
            w_wb_rst_nxt  = 1'b0;
          end else begin
            w_str_cnt_nxt = r_str_cnt + STR_W'(1);
          end
        end
        ST_STAGGER: begin
          w_stg_cnt_nxt = w_stg_inc;
          for (int k = 0; k < CORE_COUNT; k++) begin
            if (w_stg_inc == STG_W'((k + 1) * STAGGER_CYCLES)) begin
              w_release[k] = 1'b1;
            end
          end
          if (w_stg_inc == STG_W'(STG_MAX)) begin
            w_state_nxt   = ST_RUN;
            w_stg_cnt_nxt = '0;
            w_ready_nxt   = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Per-core reset: held until staggered release, then driven by a soft-reset timer.
  for (genvar k = 0; k < CORE_COUNT; k++) begin : g_core
    logic              r_req;
    logic [SOFT_W-1:0] r_timer;
    logic              r_core_rst;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_req      <= 1'b0;
        r_timer    <= '0;
        r_core_rst <= 1'b1;
      end else if (r_lock_lost) begin
        r_req      <= 1'b0;
        r_timer    <= '0;
        r_core_rst <= 1'b1;
      end else begin
        r_req <= i_core_rst_req[k] && (r_state == ST_RUN);
        if (r_req) begin
          r_timer    <= SOFT_W'(SOFT_CYCLES);
          r_core_rst <= 1'b1;
        end else if (r_timer > SOFT_W'(1)) begin
          r_timer <= r_timer - SOFT_W'(1);
        end else if (r_timer == SOFT_W'(1)) begin
          r_timer    <= '0;
          r_core_rst <= 1'b0;
        end else if (w_release[k]) begin
          r_core_rst <= 1'b0;
        end
      end
    end

    assign o_core_rst[k] = r_core_rst;
  end

  assign o_wb_rst = r_wb_rst;
  assign o_ready  = r_ready;

endmodule

// File: tb/tb_servive_rst_seq.sv
// Scoreboard bench for servive_rst_seq: stimulus queues expected output
// transitions (edge number, value); a negedge monitor compares each change.
module tb_servive_rst_seq;
  import servive_rst_seq_pkg::*;

  localparam int unsigned NC = 3;

  logic          clk  = 1'b0;
  logic          rst  = 1'b0;
  logic          lock = 1'b0;
  logic [NC-1:0] req  = '0;
  logic          wb;
  logic [NC-1:0] core;
  logic          rdy;

  servive_rst_seq #(
    .CORE_COUNT     (NC),
    .SYNC_STAGES    (2),
    .STRETCH_CYCLES (16),
    .STAGGER_CYCLES (4),
    .SOFT_CYCLES    (8)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_pll_locked   (lock),
    .i_core_rst_req (req),
    .o_wb_rst       (wb),
    .o_core_rst     (core),
    .o_ready        (rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [4:0] val;
  } ev_t;

  ev_t        exp_q[$];
  int         gcyc    = 0;
  int         base    = 0;
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         mon_en  = 1'b0;
  logic [4:0] prev    = 5'b11110;

  always @(posedge clk) gcyc <= gcyc + 1;

  // Edge index relative to the last reset release; edge 0 is the first posedge after it.
  function automatic int rel();
    return gcyc - base - 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, rel());
    end
  endtask

  task automatic expect_ev(input int e, input logic [4:0] v);
    ev_t ev;
    ev.edge_n = e;
    ev.val    = v;
    exp_q.push_back(ev);
  endtask

  // Returns at the negedge just before edge n, so inputs driven now are sampled at edge n.
  task automatic at_edge(input int n);
    while (rel() < n - 1) @(negedge clk);
  endtask

  // Output vector {o_wb_rst, o_core_rst[2:0], o_ready}.
  always @(negedge clk) begin
    logic [4:0] cur;
    ev_t        ev;
    if (mon_en) begin
      cur = {wb, core, rdy};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_change: outputs %b (was %b) at edge %0d, none queued", cur, prev, rel());
        end else begin
          ev = exp_q.pop_front();
          check("out_val", int'(cur), int'(ev.val));
          check("out_edge", rel(), ev.edge_n);
        end
        prev = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_wb", int'(wb), 1);
    check("rst_core", int'(core), 7);
    check("rst_ready", int'(rdy), 0);
    check("rst_state", int'(dut.r_state), int'(ST_LOCK));
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    base   = gcyc;
    mon_en = 1'b1;

    // Late lock, with a soft request during STAGGER that must be ignored.
    at_edge(50); lock = 1'b1;
    expect_ev(68, 5'b01110);
    expect_ev(72, 5'b01100);
    expect_ev(76, 5'b01000);
    expect_ev(80, 5'b00001);
    at_edge(69); req[2] = 1'b1;
    at_edge(70); req[2] = 1'b0;

    // Lock loss in RUN, then relock.
    at_edge(100); lock = 1'b0;
    expect_ev(103, 5'b11110);
    at_edge(120); lock = 1'b1;
    expect_ev(138, 5'b01110);
    expect_ev(142, 5'b01100);
    expect_ev(146, 5'b01000);
    expect_ev(150, 5'b00001);

    // Single soft reset on core 1.
    at_edge(200); req[1] = 1'b1;
    expect_ev(201, 5'b00101);
    expect_ev(209, 5'b00001);
    at_edge(201); req[1] = 1'b0;

    // Re-request while active reloads the timer.
    at_edge(250); req[1] = 1'b1;
    expect_ev(251, 5'b00101);
    at_edge(251); req[1] = 1'b0;
    at_edge(255); req[1] = 1'b1;
    expect_ev(264, 5'b00001);
    at_edge(256); req[1] = 1'b0;

    // Independent overlapping soft resets on cores 0 and 2.
    at_edge(300); req[0] = 1'b1;
    expect_ev(301, 5'b00011);
    at_edge(301); req[0] = 1'b0;
    at_edge(303); req[2] = 1'b1;
    expect_ev(304, 5'b01011);
    expect_ev(309, 5'b01001);
    expect_ev(312, 5'b00001);
    at_edge(304); req[2] = 1'b0;

    // Lock loss flagged on the same edge as a soft request: loss wins.
    at_edge(400); lock = 1'b0;
    expect_ev(403, 5'b11110);
    at_edge(402); req[0] = 1'b1;
    at_edge(403); req[0] = 1'b0;
    at_edge(420); lock = 1'b1;

    // Async reset mid-STRETCH, between clock edges.
    at_edge(430);
    @(posedge clk);
    #2;
    check("pre_rst_state", int'(dut.r_state), int'(ST_STRETCH));
    #1 rst = 1'b1;
    #1;
    check("async_state", int'(dut.r_state), int'(ST_LOCK));
    check("async_wb", int'(wb), 1);
    check("async_core", int'(core), 7);
    check("async_ready", int'(rdy), 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    base = gcyc;

    // Restart from LOCK with lock already high: power-up timing.
    expect_ev(18, 5'b01110);
    expect_ev(22, 5'b01100);
    expect_ev(26, 5'b01000);
    expect_ev(30, 5'b00001);

    // Async reset in RUN: outputs change without waiting for an edge.
    at_edge(40);
    @(posedge clk);
    #3;
    expect_ev(40, 5'b11110);
    rst = 1'b1;
    #1;
    check("run_rst_wb", int'(wb), 1);
    check("run_rst_core", int'(core), 7);
    check("run_rst_ready", int'(rdy), 0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    base = gcyc;
    at_edge(10);
    check("post_rst_core", int'(core), 7);
    check("post_rst_state", int'(dut.r_state), int'(ST_STRETCH));
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
